mod5_seq_monitor: RTL

MOD5_SEQ_MONITOR -- requirements
Module: mod5_seq_monitor

---
 rtl/mod5_seq_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mod5_seq_monitor.sv
// Monitor for a mod-5 counter: acquires the sequence, locks after
// LOCK_LEN good steps, then flags illegal values, breaks and idle timeouts.
module mod5_seq_monitor #(
    parameter int LOCK_LEN = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cnt_in,
    input  logic       en,
    input  logic       sticky_clr,
    output logic       locked,
    output logic [2:0] exp_cnt,
    output logic       err,
    output logic [1:0] err_code,
    output logic       err_sticky,
    output logic [7:0] wrap_cnt
);

    typedef enum logic [1:0] {
        ACQ     = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_LEN_C = 3'(LOCK_LEN);
    localparam logic [7:0] IDLE_LAST  = 8'(TIMEOUT - 1);

    function automatic logic [2:0] succ(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    state_t     r_state;
    logic [2:0] r_prev;
    logic [2:0] r_step;
    logic [7:0] r_idle;
    logic       r_locked;
    logic [2:0] r_exp;
    logic       r_err;
    logic [1:0] r_code;
    logic       r_sticky;
    logic [7:0] r_wrap;

    logic       w_legal;
    logic [2:0] w_step_nxt;
    logic       w_fault;
    logic [1:0] w_code;

    assign w_legal    = (cnt_in <= 3'd4);
    assign w_step_nxt = r_step + 3'd1;

    // Fault detection only matters while LOCKED
    always_comb begin
        w_fault = 1'b0;
        w_code  = 2'b00;
        if (r_state == LOCKED) begin
            if (en && !w_legal) begin
                w_fault = 1'b1;
                w_code  = 2'b01;
            end else if (en && cnt_in != r_exp) begin
                w_fault = 1'b1;
                w_code  = 2'b10;
            end else if (!en && r_idle == IDLE_LAST) begin
                w_fault = 1'b1;
                w_code  = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ACQ;
            r_prev   <= 3'd0;
            r_step   <= 3'd0;
            r_idle   <= 8'd0;
            r_locked <= 1'b0;
            r_exp    <= 3'd0;
            r_err    <= 1'b0;
            r_code   <= 2'b00;
            r_sticky <= 1'b0;
            r_wrap   <= 8'd0;
        end else begin
            r_err <= 1'b0;
            if (sticky_clr)
                r_sticky <= 1'b0;
            unique case (r_state)
                ACQ: begin
                    if (en && w_legal) begin
                        r_prev  <= cnt_in;
                        r_step  <= 3'd0;
                        r_state <= CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (en && !w_legal) begin
                        r_state <= ACQ;
                    end else if (en && cnt_in == succ(r_prev)) begin
                        r_prev <= cnt_in;
                        r_step <= w_step_nxt;
                        if (w_step_nxt == LOCK_LEN_C) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_exp    <= succ(cnt_in);
                            r_idle   <= 8'd0;
                        end
                    end else if (en) begin
                        r_prev <= cnt_in;
                        r_step <= 3'd0;
                    end
                end
                LOCKED: begin
                    if (w_fault) begin
                        r_state  <= ACQ;
                        r_locked <= 1'b0;
                        r_exp    <= 3'd0;
                        r_idle   <= 8'd0;
                        r_err    <= 1'b1;
                        r_code   <= w_code;
                        r_sticky <= 1'b1;
                    end else if (en) begin
                        r_exp  <= succ(r_exp);
                        r_idle <= 8'd0;
                        if (cnt_in == 3'd0 && r_wrap != 8'hFF)
                            r_wrap <= r_wrap + 8'd1;
                    end else begin
                        r_idle <= r_idle + 8'd1;
                    end
                end
                default: begin
                    r_state <= ACQ;
                end
            endcase
        end
    end

    assign locked     = r_locked;
    assign exp_cnt    = r_exp;
    assign err        = r_err;
    assign err_code   = r_code;
    assign err_sticky = r_sticky;
    assign wrap_cnt   = r_wrap;

endmodule
